// File: rtl/xbar_pkg.sv
// Shared types and constants for the crossbar slave-side blocks.
package xbar_pkg;

  localparam int XBAR_DW = 32;
  localparam int LAT_W   = 4;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK_DLY  = 2'd1,
    RESP_DLY = 2'd2
  } slv_state_e;

endpackage

// File: rtl/xbar_slave_mem.sv
// Single-port word memory for the slave responder: synchronous write,
// registered read into a holding buffer, whole array cleared on reset.
module xbar_slave_mem #(
  parameter int DW    = 32,
  parameter int DEPTH = 256,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [IW-1:0] i_idx,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rd_buf
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_buf <= '0;
    end else begin
      if (i_we) r_mem[i_idx] <= i_wdata;
      if (i_re) r_rd_buf <= r_mem[i_idx];
    end
  end

  assign o_rd_buf = r_rd_buf;

endmodule

// File: rtl/xbar_slave_responder.sv
// Crossbar slave-port responder: one transaction at a time, ack after
// ACK_LAT extra cycles, read response RESP_LAT extra cycles after ack.
module xbar_slave_responder
  import xbar_pkg::*;
#(
  parameter int AW       = 30,
  parameter int DW       = XBAR_DW,
  parameter int DEPTH    = 256,
  parameter int ACK_LAT  = 1,
  parameter int RESP_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          cmd,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ack,
  output logic          resp,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          proto_err
);

  localparam int IW = $clog2(DEPTH);
  // The capture cycle itself counts as the first ack-delay cycle.
  localparam logic [LAT_W-1:0] ACK_LOAD  = (ACK_LAT > 0) ? LAT_W'(ACK_LAT - 1) : '0;
  localparam logic [LAT_W-1:0] RESP_LOAD = LAT_W'(RESP_LAT);

  slv_state_e       r_state, w_state_nxt;
  logic [LAT_W-1:0] r_cnt, w_cnt_nxt;
  cmd_e             r_cmd;
  logic [IW-1:0]    r_idx;
  logic [DW-1:0]    r_wdata;
  logic             r_ack, r_resp, r_proto_err;
  logic [DW-1:0]    r_rdata;

  logic             w_fire, w_resp_fire, w_accept;
  cmd_e             w_cmd;
  logic [IW-1:0]    w_idx;
  logic [DW-1:0]    w_wdata;
  logic [DW-1:0]    w_rd_buf;
  logic             w_unused_addr_hi;

  assign w_unused_addr_hi = ^addr[AW-1:IW];
  assign w_accept         = req && (r_state == IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fire      = 1'b0;
    w_resp_fire = 1'b0;
    w_cmd       = r_cmd;
    w_idx       = r_idx;
    w_wdata     = r_wdata;
    unique case (r_state)
      IDLE: begin
        w_cmd   = cmd_e'(cmd);
        w_idx   = addr[IW-1:0];
        w_wdata = wdata;
        if (req) begin
          if (ACK_LAT == 0) begin
            w_fire = 1'b1;
            if (w_cmd == CMD_READ) begin
              w_state_nxt = RESP_DLY;
              w_cnt_nxt   = RESP_LOAD;
            end
          end else begin
            w_state_nxt = ACK_DLY;
            w_cnt_nxt   = ACK_LOAD;
          end
        end
      end
      ACK_DLY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_fire = 1'b1;
          if (r_cmd == CMD_READ) begin
            w_state_nxt = RESP_DLY;
            w_cnt_nxt   = RESP_LOAD;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      RESP_DLY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_resp_fire = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ack       <= 1'b0;
      r_resp      <= 1'b0;
      r_rdata     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_fire;
      r_resp  <= w_resp_fire;
      if (w_resp_fire) r_rdata <= w_rd_buf;
      if (req && (r_state != IDLE)) r_proto_err <= 1'b1;
    end
  end

  // Captured request fields
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_cmd   <= cmd_e'(cmd);
      r_idx   <= addr[IW-1:0];
      r_wdata <= wdata;
    end
  end

  xbar_slave_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_fire && (w_cmd == CMD_WRITE)),
    .i_re     (w_fire && (w_cmd == CMD_READ)),
    .i_idx    (w_idx),
    .i_wdata  (w_wdata),
    .o_rd_buf (w_rd_buf)
  );

  assign ack       = r_ack;
  assign resp      = r_resp;
  assign rdata     = r_rdata;
  assign busy      = (r_state != IDLE);
  assign proto_err = r_proto_err;

endmodule
